// File: rtl/uart_frame_rx_if.sv
// Byte-stream and status bundle for uart_frame_rx.
//   in_data/in_valid/in_ready     : byte stream from the UART receiver
//   out_data/out_valid/out_ready  : validated payload stream, out_last on final byte
//   frame_ok/frame_err/err_code   : per-frame status pulses and drop cause
// modport master is the decoder side, modport slave is the surrounding logic.
interface uart_frame_rx_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_code
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/uart_frame_rx.sv
// Sync-delimited frame decoder behind the UART receiver.
// Frame: SYNC_BYTE, LEN, LEN payload bytes, CHK (CHK = LEN ^ payload bytes).
// Payload is buffered and forwarded only after the checksum passes;
// bad length, bad checksum and inter-byte timeout drop the frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_frame_rx_if.master (byte in, payload out, status)
module uart_frame_rx #(
    parameter int unsigned MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_frame_rx_if.master  bus
);

    localparam int unsigned IDX_W     = $clog2(MAX_LEN + 1);
    localparam int unsigned ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned BUF_DEPTH = 1 << ADDR_W;
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]       ERR_LEN   = 2'd1;
    localparam logic [1:0]       ERR_CHK   = 2'd2;
    localparam logic [1:0]       ERR_TMO   = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0] rd_idx_nxt;
    logic [7:0]       chk_q, chk_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             in_ready_q, in_ready_d;
    logic             buf_we;
    logic             in_fire;
    logic             out_fire;
    logic             in_frame;

    // Payload buffer; depth rounded up to a power of two so every address is in range.
    logic [7:0] buf_q [BUF_DEPTH];

    assign in_fire    = bus.in_valid && in_ready_q;
    assign out_fire   = out_valid_q && bus.out_ready;
    assign in_frame   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    assign rd_idx_nxt = rd_idx_q + IDX_W'(1);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rd_idx_d    = rd_idx_q;
        chk_d       = chk_q;
        tmo_d       = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        buf_we      = 1'b0;

        // Idle counter only runs while a frame is open; any accepted byte restarts it.
        if (in_frame && !in_fire) begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
        end

        unique case (state_q)
            S_HUNT: begin
                if (in_fire && bus.in_data == SYNC_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (in_fire) begin
                    if (bus.in_data == 8'd0 || bus.in_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = S_HUNT;
                    end else begin
                        len_d   = IDX_W'(bus.in_data);
                        chk_d   = bus.in_data;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (in_fire) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ bus.in_data;
                    idx_d  = idx_q + IDX_W'(1);
                    if (idx_q == len_q - IDX_W'(1)) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (in_fire) begin
                    if (bus.in_data == chk_q) begin
                        // First payload byte is presented together with the frame_ok pulse.
                        frame_ok_d  = 1'b1;
                        rd_idx_d    = '0;
                        out_valid_d = 1'b1;
                        out_data_d  = buf_q[0];
                        out_last_d  = (len_q == IDX_W'(1));
                        state_d     = S_DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (out_fire) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = S_HUNT;
                    end else begin
                        rd_idx_d   = rd_idx_nxt;
                        out_data_d = buf_q[ADDR_W'(rd_idx_nxt)];
                        out_last_d = (rd_idx_nxt == len_q - IDX_W'(1));
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        // Expiry only when no byte lands this cycle: a simultaneous byte wins.
        if (in_frame && !in_fire && tmo_q >= TMO_LAST) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_TMO;
            tmo_d       = '0;
            state_d     = S_HUNT;
        end

        in_ready_d = (state_d != S_DRAIN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            len_q       <= '0;
            idx_q       <= '0;
            rd_idx_q    <= '0;
            chk_q       <= '0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rd_idx_q    <= rd_idx_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Payload buffer write; contents are don't-care outside a frame.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[ADDR_W'(idx_q)] <= bus.in_data;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_code  = err_code_q;

endmodule
